cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Schedules the single common data bus (CDB) shared by three result producers: ALU1, ALU2 and the load/store buffer.
- Each producer pushes {rob tag, value} into a private small FIFO. A round-robin arbiter grants one FIFO head per cycle onto registered CDB outputs.
- The CDB outputs drive the reservation station's rs_update_flag/rs_commit_rename/rs_value and the ROB writeback.
- rs_flush from the predictor discards all pending results.

Parameters:
FIFO_DEPTH, 2, entries per source FIFO; power of two, >=2
TAG_W, 4, ROB rename tag width
DATA_W, 32, result value width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-high
rdy  in  1  global ready; low = freeze all state
rs_flush  in  1  misprediction flush
alu1_valid  in  1  ALU1 result push
alu1_tag  in  TAG_W  ALU1 rob tag
alu1_value  in  DATA_W  ALU1 result
alu1_ready  out  1  ALU1 FIFO can accept
alu2_valid / alu2_tag / alu2_value / alu2_ready  as ALU1, for ALU2
lsb_valid / lsb_tag / lsb_value / lsb_ready  as ALU1, for LSB
cdb_valid  out  1  broadcast valid this cycle
cdb_tag  out  TAG_W  broadcast rob tag
cdb_value  out  DATA_W  broadcast value
cdb_src  out  2  granted source: 0=ALU1, 1=ALU2, 2=LSB
overflow_err  out  1  sticky; a push occurred while ready was low

Behaviour:
- Reset (rst=1 at edge):
  - All FIFOs empty; rr_ptr=0.
  - cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_src=0, overflow_err=0.
  - All *_ready=1 the cycle after reset.
  - Reset overrides rdy and rs_flush, including mid-operation.
- rdy=0 (rst=0): no state changes at all. FIFOs, rr_ptr and the CDB output registers hold. Pushes are ignored and do not set overflow_err.
- Precedence with rdy=1: rst > rs_flush > normal operation.
- rs_flush=1:
  - All FIFOs emptied; same-cycle pushes discarded.
  - cdb_valid<=0 next cycle; rr_ptr<=0.
  - overflow_err holds its value.
- Ready:
  - src_ready = (count < FIFO_DEPTH). Combinational from the registered count only, with no dependence on same-cycle pops.
  - A push with ready=0 is dropped and sets overflow_err, which stays set until rst.
- Push: src_valid && src_ready at an edge writes the tail; count+1.
- Arbitration, each rdy=1 non-flush edge:
  - Candidates are the non-empty FIFOs, judged on state before the edge. Same-edge pushes are not visible to arbitration.
  - Search order starts at rr_ptr, then (rr_ptr+1) mod 3, then (rr_ptr+2) mod 3.
  - First candidate k wins: its head is popped and registered to cdb_tag/cdb_value; cdb_src<=k; cdb_valid<=1; rr_ptr<=(k+1) mod 3.
  - No candidate: cdb_valid<=0. cdb_tag/cdb_value/cdb_src hold; rr_ptr holds.
- Latency: a push at edge E appears on the CDB at the earliest at edge E+1, visible for exactly one cycle.
- Throughput: one result per cycle total.
- Simultaneous push and pop on the same FIFO: count unchanged; FIFO order preserved.
- Pointers: head/tail are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- Per-source order: results from one source broadcast in push order.
- Fairness: every non-empty source is granted within 3 consecutive rdy=1 non-flush cycles.

Decomposition:
- Shared package (cdb_pkg):
  - TAG_W, DATA_W
  - source indices SRC_ALU1=0, SRC_ALU2=1, SRC_LSB=2
  - NSRC=3
  - CDB payload layout {tag, value}
- Sub-module cdb_src_fifo, instantiated three times:
  - inputs push/pop/flush/rdy/din
  - outputs dout/empty/ready/count

Test Plan:
- Reset, then single push alu1 tag=3 value=0x1234 -> next cycle cdb_valid=1, tag=3, value=0x1234, src=0; following cycle cdb_valid=0.
- All three sources push in the same cycle (tags 1, 2, 5) from reset -> three consecutive broadcasts with src 0, 1, 2; then rr_ptr=0.
- LSB pushes tags 7, 8 back-to-back while ALU1 continuously pushes -> CDB alternates; LSB tags 7 and 8 each appear within 3 cycles of reaching the head, in order 7 then 8.
- Fill alu2 FIFO (2 pushes, with ALU1 holding the grant) -> alu2_ready=0; third push -> dropped, overflow_err=1 and stays 1 after rs_flush.
- Pending entries in all FIFOs plus rs_flush with a same-cycle lsb push -> next cycle cdb_valid=0, all *_ready=1, no stale tag is ever broadcast.
- rdy=0 for 4 cycles with pending entries -> CDB outputs and counts frozen; when rdy returns to 1, broadcasts resume in the same order as without the stall.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter: widths, source indices, payload layout.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package cdb_pkg;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int NSRC   = 3;

  // Producer index; also the encoding driven on cdb_src.
  typedef enum logic [1:0] {
    SRC_ALU1 = 2'd0,
    SRC_ALU2 = 2'd1,
    SRC_LSB  = 2'd2
  } src_e;

  // Result payload as stored in each source FIFO: tag in the upper bits, value below.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } cdb_payload_t;

  // Round-robin successor over the three sources.
  function automatic logic [1:0] next_src(input logic [1:0] k);
    return (k >= 2'(SRC_LSB)) ? 2'(SRC_ALU1) : k + 2'd1;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-producer result FIFO feeding the CDB arbiter.
// Latency: a push is visible at the head (empty=0) the cycle after it is written.
// Backpressure: ready = count < DEPTH from registered state only; pushes while not ready are dropped.
//
// Ports: clk/rst (sync, active-high), rdy (global freeze), flush (empty everything),
//        push/din (write request + data), pop (remove head), dout (head data),
//        empty, ready, count (occupancy, log2(DEPTH)+1 bits).
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 36
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       empty,
  output logic                       ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign empty = (count_q == '0);
  assign ready = (count_q < CNT_W'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[head_q];

  assign wr_en = rdy && !flush && push && ready;
  assign rd_en = rdy && !flush && pop && !empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (rdy && flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) begin
        mem_d[tail_q] = din;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (rd_en) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin scheduler of the common data bus over ALU1, ALU2 and the load/store buffer.
// Latency: a result pushed at edge E is broadcast at the earliest at edge E+1, for one cycle.
// Backpressure: per-source *_ready from FIFO occupancy; a push while not ready is dropped and sets overflow_err.
//
// Ports: clk/rst (sync, active-high), rdy (global freeze), rs_flush (discard all pending),
//        <src>_valid/_tag/_value/_ready for alu1, alu2, lsb,
//        cdb_valid/cdb_tag/cdb_value/cdb_src (registered broadcast), overflow_err (sticky).
module cdb_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = 4,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rs_flush,
  input  logic              alu1_valid,
  input  logic [TAG_W-1:0]  alu1_tag,
  input  logic [DATA_W-1:0] alu1_value,
  output logic              alu1_ready,
  input  logic              alu2_valid,
  input  logic [TAG_W-1:0]  alu2_tag,
  input  logic [DATA_W-1:0] alu2_value,
  output logic              alu2_ready,
  input  logic              lsb_valid,
  input  logic [TAG_W-1:0]  lsb_tag,
  input  logic [DATA_W-1:0] lsb_value,
  output logic              lsb_ready,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_value,
  output logic [1:0]        cdb_src,
  output logic              overflow_err
);
  import cdb_pkg::*;

  localparam int PAY_W = TAG_W + DATA_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NSRC-1:0]  in_vld;
  logic [NSRC-1:0]  fifo_rdy;
  logic [NSRC-1:0]  fifo_empty;
  logic [NSRC-1:0]  pop;
  logic [PAY_W-1:0] in_dat    [NSRC];
  logic [PAY_W-1:0] fifo_dout [NSRC];
  logic [CNT_W-1:0] fifo_cnt  [NSRC];
  logic             active;

  logic [1:0]        rr_ptr_q,    rr_ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
  logic [DATA_W-1:0] cdb_value_q, cdb_value_d;
  logic [1:0]        cdb_src_q,   cdb_src_d;
  logic              overflow_q,  overflow_d;

  logic [1:0] order [NSRC];
  logic       grant_vld;
  logic [1:0] grant_idx;

  assign in_vld            = {lsb_valid, alu2_valid, alu1_valid};
  assign in_dat[SRC_ALU1]  = {alu1_tag, alu1_value};
  assign in_dat[SRC_ALU2]  = {alu2_tag, alu2_value};
  assign in_dat[SRC_LSB]   = {lsb_tag,  lsb_value};
  assign alu1_ready        = fifo_rdy[SRC_ALU1];
  assign alu2_ready        = fifo_rdy[SRC_ALU2];
  assign lsb_ready         = fifo_rdy[SRC_LSB];
  assign active            = rdy && !rs_flush;

  for (genvar g = 0; g < NSRC; g++) begin : g_fifo
    assign pop[g] = active && grant_vld && (grant_idx == 2'(g));

    cdb_src_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (PAY_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .rdy   (rdy),
      .flush (rs_flush),
      .push  (in_vld[g]),
      .pop   (pop[g]),
      .din   (in_dat[g]),
      .dout  (fifo_dout[g]),
      .empty (fifo_empty[g]),
      .ready (fifo_rdy[g]),
      .count (fifo_cnt[g])
    );
  end

  // Occupancy is exported by each FIFO for debug visibility; the arbiter only needs empty.
  logic unused_cnt;
  assign unused_cnt = ^{fifo_cnt[0], fifo_cnt[1], fifo_cnt[2]};

  // Walk the search order backwards so the earliest non-empty source in the order wins.
  always_comb begin
    order[0]  = rr_ptr_q;
    order[1]  = next_src(rr_ptr_q);
    order[2]  = next_src(next_src(rr_ptr_q));
    grant_vld = 1'b0;
    grant_idx = rr_ptr_q;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (!fifo_empty[order[i]]) begin
        grant_vld = 1'b1;
        grant_idx = order[i];
      end
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    cdb_src_d   = cdb_src_q;
    overflow_d  = overflow_q;
    if (rdy) begin
      if (rs_flush) begin
        cdb_valid_d = 1'b0;
        rr_ptr_d    = 2'(SRC_ALU1);
      end else begin
        cdb_valid_d = grant_vld;
        if (grant_vld) begin
          {cdb_tag_d, cdb_value_d} = fifo_dout[grant_idx];
          cdb_src_d                = grant_idx;
          rr_ptr_d                 = next_src(grant_idx);
        end
        if ((in_vld & ~fifo_rdy) != '0) begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
      cdb_src_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
      cdb_src_q   <= cdb_src_d;
      overflow_q  <= overflow_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_tag      = cdb_tag_q;
  assign cdb_value    = cdb_value_q;
  assign cdb_src      = cdb_src_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-based reference model plus scoreboard.
// Latency: model predicts each broadcast at the edge the DUT registers it.
// Backpressure: model tracks per-source occupancy to predict *_ready and overflow_err.
module tb_cdb_arbiter;

  localparam int DEPTH = 2;
  localparam int TW    = 4;
  localparam int DW    = 32;
  localparam int PW    = TW + DW;

  logic          clk = 1'b0;
  logic          rst, rdy, rs_flush;
  logic          alu1_valid, alu2_valid, lsb_valid;
  logic [TW-1:0] alu1_tag, alu2_tag, lsb_tag;
  logic [DW-1:0] alu1_value, alu2_value, lsb_value;
  logic          alu1_ready, alu2_ready, lsb_ready;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_value;
  logic [1:0]    cdb_src;
  logic          overflow_err;

  always #5 clk = ~clk;

  cdb_arbiter #(.FIFO_DEPTH(DEPTH), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rs_flush(rs_flush),
    .alu1_valid(alu1_valid), .alu1_tag(alu1_tag), .alu1_value(alu1_value), .alu1_ready(alu1_ready),
    .alu2_valid(alu2_valid), .alu2_tag(alu2_tag), .alu2_value(alu2_value), .alu2_ready(alu2_ready),
    .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_value(lsb_value), .lsb_ready(lsb_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_src(cdb_src),
    .overflow_err(overflow_err)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]    src;
    logic [TW-1:0] tag;
    logic [DW-1:0] value;
  } bc_t;

  logic [PW-1:0] q0[$], q1[$], q2[$];
  bc_t           exp_q[$];
  int            rr;
  bit            m_vld, m_new, m_ovf, started;
  logic [TW-1:0] m_tag;
  logic [DW-1:0] m_value;
  logic [1:0]    m_src;
  int            m_sz [3];
  int            m_win;
  logic [PW-1:0] m_p;
  bc_t           m_bc;

  function automatic int qsize(int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [PW-1:0] qpop(int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void qpush(int k, logic [PW-1:0] v);
    case (k)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic bit in_v(int k);
    case (k)
      0:       return alu1_valid;
      1:       return alu2_valid;
      default: return lsb_valid;
    endcase
  endfunction

  function automatic logic [PW-1:0] in_p(int k);
    case (k)
      0:       return {alu1_tag, alu1_value};
      1:       return {alu2_tag, alu2_value};
      default: return {lsb_tag, lsb_value};
    endcase
  endfunction

  always @(posedge clk) begin
    m_new = 1'b0;
    if (rst) begin
      q0.delete(); q1.delete(); q2.delete();
      rr = 0; m_vld = 1'b0; m_ovf = 1'b0;
      m_tag = '0; m_value = '0; m_src = '0;
    end else if (rdy) begin
      if (rs_flush) begin
        q0.delete(); q1.delete(); q2.delete();
        rr = 0; m_vld = 1'b0;
      end else begin
        for (int k = 0; k < 3; k++) m_sz[k] = qsize(k);
        m_win = -1;
        for (int i = 0; i < 3; i++) begin
          if (m_win < 0 && m_sz[(rr + i) % 3] > 0) m_win = (rr + i) % 3;
        end
        if (m_win >= 0) begin
          m_p      = qpop(m_win);
          m_vld    = 1'b1;
          m_tag    = m_p[PW-1:DW];
          m_value  = m_p[DW-1:0];
          m_src    = 2'(m_win);
          rr       = (m_win + 1) % 3;
          m_bc.src = m_src; m_bc.tag = m_tag; m_bc.value = m_value;
          exp_q.push_back(m_bc);
          m_new    = 1'b1;
        end else begin
          m_vld = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
          if (in_v(k)) begin
            if (m_sz[k] < DEPTH) qpush(k, in_p(k));
            else                 m_ovf = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("cdb_valid",    64'(cdb_valid),    64'(m_vld));
      chk("cdb_tag",      64'(cdb_tag),      64'(m_tag));
      chk("cdb_value",    64'(cdb_value),    64'(m_value));
      chk("cdb_src",      64'(cdb_src),      64'(m_src));
      chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
      chk("alu1_ready",   64'(alu1_ready),   64'(qsize(0) < DEPTH));
      chk("alu2_ready",   64'(alu2_ready),   64'(qsize(1) < DEPTH));
      chk("lsb_ready",    64'(lsb_ready),    64'(qsize(2) < DEPTH));
      if (m_new) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_bcast", 64'(1), 64'(0));
        end else begin
          m_bc = exp_q.pop_front();
          chk("sb_valid", 64'(cdb_valid), 64'(1));
          chk("sb_tag",   64'(cdb_tag),   64'(m_bc.tag));
          chk("sb_value", 64'(cdb_value), 64'(m_bc.value));
          chk("sb_src",   64'(cdb_src),   64'(m_bc.src));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle_in();
    alu1_valid = 1'b0; alu2_valid = 1'b0; lsb_valid = 1'b0;
  endtask

  task automatic drive(int k, logic [TW-1:0] t, logic [DW-1:0] v);
    case (k)
      0:       begin alu1_valid = 1'b1; alu1_tag = t; alu1_value = v; end
      1:       begin alu2_valid = 1'b1; alu2_tag = t; alu2_value = v; end
      default: begin lsb_valid  = 1'b1; lsb_tag  = t; lsb_value  = v; end
    endcase
  endtask

  task automatic run(int n);
    idle_in();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; idle_in();
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rs_flush = 1'b0;
    alu1_tag = '0; alu2_tag = '0; lsb_tag = '0;
    alu1_value = '0; alu2_value = '0; lsb_value = '0;
    idle_in();
    step();
    started = 1'b1;
    do_reset();
    step();

    // single push
    drive(0, 4'd3, 32'h1234); step();
    run(3);

    // all three at once from a fresh round-robin pointer
    do_reset();
    drive(0, 4'd1, 32'h11); drive(1, 4'd2, 32'h22); drive(2, 4'd5, 32'h55); step();
    run(4);
    drive(1, 4'd9, 32'h99); step();   // rr back at ALU1; ALU2 alone still wins
    run(2);

    // LSB 7,8 against a continuously pushing ALU1
    for (int c = 0; c < 10; c++) begin
      idle_in();
      if (alu1_ready) drive(0, 4'(c), 32'hA000 + 32'(c));
      if (c == 0) drive(2, 4'd7, 32'h7777);
      if (c == 1) drive(2, 4'd8, 32'h8888);
      step();
    end
    run(4);

    // fill ALU2 while ALU1 takes the grant, then overflow, then flush
    do_reset();
    drive(0, 4'd4, 32'h44); drive(1, 4'd10, 32'hB0); step();
    idle_in(); drive(1, 4'd11, 32'hB1); step();
    idle_in(); drive(1, 4'd12, 32'hB2); step();
    idle_in(); step();
    rs_flush = 1'b1; step();
    rs_flush = 1'b0;
    run(3);

    // flush with pending entries everywhere and a same-cycle LSB push
    do_reset();
    drive(0, 4'd1, 32'hC1); drive(1, 4'd2, 32'hC2); drive(2, 4'd3, 32'hC3); step();
    idle_in(); drive(0, 4'd4, 32'hC4); drive(1, 4'd5, 32'hC5); drive(2, 4'd6, 32'hC6); step();
    idle_in(); drive(2, 4'd15, 32'hDEAD); rs_flush = 1'b1; step();
    rs_flush = 1'b0;
    run(4);

    // stall with pending entries; pushes during stall are ignored
    drive(0, 4'd1, 32'hE1); drive(1, 4'd2, 32'hE2); drive(2, 4'd3, 32'hE3); step();
    idle_in(); drive(0, 4'd4, 32'hE4); step();
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle_in(); drive(i % 3, 4'd13, 32'hBAD0 + 32'(i)); step();
    end
    rdy = 1'b1;
    run(6);

    // randomized traffic with stalls, flushes and occasional reset
    for (int c = 0; c < 600; c++) begin
      idle_in();
      rdy      = ($urandom_range(9) != 0);
      rs_flush = ($urandom_range(24) == 0);
      rst      = ($urandom_range(149) == 0);
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(2) != 0) drive(k, 4'($urandom_range(15)), $urandom);
      end
      step();
    end
    rst = 1'b0; rdy = 1'b1; rs_flush = 1'b0;
    run(8);
    chk("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
